// File: rtl/mux_nto1_pipe.sv
// Registered N-to-1 multiplexer with a STAGES-deep pipeline, stall/flush control,
// per-stage valid/error tracking and a saturating out-of-range select counter.
module mux_nto1_pipe #(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2,
  parameter int STAGES = 1,
  parameter int ERR_W  = 8
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [NUM_IN*WIDTH-1:0]  in_bus,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     in_valid,
  input  logic                     stall,
  input  logic                     flush,
  output logic [WIDTH-1:0]         out,
  output logic                     out_valid,
  output logic                     sel_err,
  output logic [ERR_W-1:0]         err_count
);

  logic [WIDTH-1:0] mux_data;
  logic             sel_oob;

  always_comb begin
    mux_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) mux_data = in_bus[k*WIDTH +: WIDTH];
    end
  end

  // With a fully populated select space no select value can be out of range.
  generate
    if (NUM_IN < (1 << SEL_W)) begin : g_oob
      assign sel_oob = (sel > SEL_W'(NUM_IN - 1));
    end else begin : g_no_oob
      assign sel_oob = 1'b0;
    end
  endgenerate

  logic [WIDTH-1:0] data_q  [STAGES];
  logic [WIDTH-1:0] data_d  [STAGES];
  logic             valid_q [STAGES];
  logic             valid_d [STAGES];
  logic             err_q   [STAGES];
  logic             err_d   [STAGES];

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign data_d[gi]  = mux_data;
        assign valid_d[gi] = in_valid;
        assign err_d[gi]   = in_valid & sel_oob;
      end else begin : g_body
        assign data_d[gi]  = data_q[gi-1];
        assign valid_d[gi] = valid_q[gi-1];
        assign err_d[gi]   = err_q[gi-1];
      end

      always_ff @(posedge Clk) begin
        if (Rst || flush) begin
          data_q[gi]  <= '0;
          valid_q[gi] <= 1'b0;
          err_q[gi]   <= 1'b0;
        end else if (!stall) begin
          data_q[gi]  <= data_d[gi];
          valid_q[gi] <= valid_d[gi];
          err_q[gi]   <= err_d[gi];
        end
      end
    end
  endgenerate

  logic [ERR_W-1:0] err_count_q;
  logic [ERR_W-1:0] err_count_d;

  // Only accepted selections count; flush and stall both drop the input.
  always_comb begin
    err_count_d = err_count_q;
    if (!flush && !stall && in_valid && sel_oob && (err_count_q != {ERR_W{1'b1}}))
      err_count_d = err_count_q + 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Rst) err_count_q <= '0;
    else     err_count_q <= err_count_d;
  end

  assign out       = data_q[STAGES-1];
  assign out_valid = valid_q[STAGES-1];
  assign sel_err   = err_q[STAGES-1];
  assign err_count = err_count_q;

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Directed and randomized checks of mux_nto1_pipe against a queue-based reference
// model: NUM_IN=3 so select 3 exercises the out-of-range path, STAGES=2.
module tb_mux_nto1_pipe;
  localparam int W  = 5;
  localparam int N  = 3;
  localparam int SW = 2;
  localparam int ST = 2;
  localparam int EW = 8;
  localparam int CMAX = (1 << EW) - 1;

  typedef struct {
    logic [W-1:0] d;
    bit           v;
    bit           e;
  } ent_t;

  logic            Clk = 1'b0;
  logic            Rst;
  logic [N*W-1:0]  in_bus;
  logic [SW-1:0]   sel;
  logic            in_valid;
  logic            stall;
  logic            flush;
  logic [W-1:0]    out;
  logic            out_valid;
  logic            sel_err;
  logic [EW-1:0]   err_count;

  mux_nto1_pipe #(.WIDTH(W), .NUM_IN(N), .SEL_W(SW), .STAGES(ST), .ERR_W(EW)) dut (
    .Clk(Clk), .Rst(Rst), .in_bus(in_bus), .sel(sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .out(out), .out_valid(out_valid),
    .sel_err(sel_err), .err_count(err_count)
  );

  always #5 Clk = ~Clk;

  int   checks = 0;
  int   errors = 0;
  ent_t pipe[$];
  int   exp_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_pipe();
    ent_t z;
    z.d = '0; z.v = 1'b0; z.e = 1'b0;
    pipe = {};
    for (int i = 0; i < ST; i++) pipe.push_back(z);
  endtask

  task automatic check_model(input string tag);
    ent_t t;
    t = pipe[$];
    check({tag, ".out"},       32'(out),       32'(t.d));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(t.v));
    check({tag, ".sel_err"},   32'(sel_err),   32'(t.e));
    check({tag, ".err_count"}, 32'(err_count), 32'(exp_cnt));
  endtask

  // One clock edge: advance the reference model with the inputs seen at the edge,
  // then compare every output 1 time unit later.
  task automatic tick(input string tag);
    ent_t e;
    @(posedge Clk);
    if (Rst) begin
      clear_pipe();
      exp_cnt = 0;
    end else if (flush) begin
      clear_pipe();
    end else if (!stall) begin
      e.d = (int'(sel) < N) ? in_bus[int'(sel)*W +: W] : '0;
      e.v = in_valid;
      e.e = in_valid && (int'(sel) >= N);
      pipe.push_front(e);
      void'(pipe.pop_back());
      if (e.e && exp_cnt < CMAX) exp_cnt++;
    end
    #1;
    check_model(tag);
  endtask

  task automatic drive(input logic v, input logic [SW-1:0] s, input logic st, input logic fl);
    in_valid = v; sel = s; stall = st; flush = fl;
  endtask

  int unsigned r;

  initial begin
    Rst = 1'b1;
    in_bus = {5'd17, 5'd9, 5'd4};
    drive(1'b0, '0, 1'b0, 1'b0);
    clear_pipe();
    tick("reset0");
    tick("reset1");
    check("rst.out", 32'(out), 0);
    check("rst.valid", 32'(out_valid), 0);
    check("rst.err", 32'(sel_err), 0);
    check("rst.cnt", 32'(err_count), 0);
    Rst = 1'b0;
    $display("step reset done");

    // Basic select and two-cycle latency.
    drive(1'b1, 2'd0, 1'b0, 1'b0); tick("basic0");
    check("lat.valid_early", 32'(out_valid), 0);
    drive(1'b1, 2'd1, 1'b0, 1'b0); tick("basic1");
    check("lat.out_first", 32'(out), 4);
    check("lat.valid_first", 32'(out_valid), 1);
    drive(1'b1, 2'd2, 1'b0, 1'b0); tick("basic2");
    check("basic.out9", 32'(out), 9);
    drive(1'b0, 2'd0, 1'b0, 1'b0); tick("basic3");
    check("basic.out17", 32'(out), 17);
    tick("basic4");
    $display("step basic select done");

    // Out-of-range select and saturation.
    drive(1'b1, 2'd3, 1'b0, 1'b0); tick("oob0");
    drive(1'b0, 2'd0, 1'b0, 1'b0); tick("oob1");
    check("oob.out", 32'(out), 0);
    check("oob.valid", 32'(out_valid), 1);
    check("oob.sel_err", 32'(sel_err), 1);
    check("oob.cnt", 32'(err_count), 1);
    drive(1'b1, 2'd3, 1'b0, 1'b0);
    repeat (300) tick("oob_sat");
    drive(1'b0, 2'd0, 1'b0, 1'b0);
    tick("oob_sat_d0"); tick("oob_sat_d1");
    check("sat.cnt", 32'(err_count), CMAX);
    $display("step out-of-range saturation done");

    // Stall: entries hold, then emerge in order.
    drive(1'b1, 2'd0, 1'b0, 1'b0); tick("stall0");
    drive(1'b1, 2'd1, 1'b0, 1'b0); tick("stall1");
    drive(1'b1, 2'd2, 1'b1, 1'b0); tick("stall2");
    check("stall.hold_out", 32'(out), 4);
    tick("stall3");
    check("stall.hold_out2", 32'(out), 4);
    drive(1'b1, 2'd2, 1'b0, 1'b0); tick("stall4");
    check("stall.out9", 32'(out), 9);
    drive(1'b0, 2'd0, 1'b0, 1'b0); tick("stall5");
    check("stall.out17", 32'(out), 17);
    tick("stall6");
    $display("step stall done");

    // Flush overrides a simultaneous stall.
    drive(1'b1, 2'd0, 1'b0, 1'b0); tick("flush0");
    drive(1'b1, 2'd1, 1'b0, 1'b0); tick("flush1");
    drive(1'b1, 2'd1, 1'b1, 1'b1); tick("flush2");
    check("flush.valid", 32'(out_valid), 0);
    check("flush.out", 32'(out), 0);
    check("flush.cnt", 32'(err_count), CMAX);
    drive(1'b1, 2'd2, 1'b0, 1'b0); tick("flush3");
    drive(1'b0, 2'd0, 1'b0, 1'b0); tick("flush4");
    check("flush.new_out", 32'(out), 17);
    check("flush.new_valid", 32'(out_valid), 1);
    $display("step flush done");

    // Reset mid-stream with a partial error count.
    Rst = 1'b1; tick("rst_mid0"); Rst = 1'b0;
    drive(1'b1, 2'd3, 1'b0, 1'b0);
    repeat (5) tick("rst_mid_err");
    drive(1'b1, 2'd1, 1'b0, 1'b0); tick("rst_mid_f0"); tick("rst_mid_f1");
    check("rstmid.cnt5", 32'(err_count), 5);
    check("rstmid.full", 32'(out_valid), 1);
    // A reset pulse that spans no clock edge must change nothing.
    Rst = 1'b1; #2; Rst = 1'b0; #1;
    check_model("rst_noedge");
    check("rstnoedge.cnt", 32'(err_count), 5);
    Rst = 1'b1; tick("rst_mid1"); Rst = 1'b0;
    check("rstmid.out", 32'(out), 0);
    check("rstmid.valid", 32'(out_valid), 0);
    check("rstmid.cnt0", 32'(err_count), 0);
    $display("step reset mid-stream done");

    // Randomized traffic with stall, flush and occasional reset.
    for (int i = 0; i < 4000; i++) begin
      in_bus = (N*W)'($urandom);
      sel = SW'($urandom_range(0, 3));
      in_valid = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 99);
      stall = (r < 20);
      flush = (r >= 20 && r < 25) || (r == 0);
      Rst = ($urandom_range(0, 299) == 0);
      tick("rand");
    end
    Rst = 1'b0;
    $display("step random traffic done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
